// File: rtl/store_buffer_ctrl.sv
// Store buffer between the MEM stage and data memory: a circular FIFO of aligned
// stores drained by a request/acknowledge FSM. Define STORE_BUF_MERGE_EN to enable merging.
module store_buffer_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] ty, input logic [1:0] a);
    case (ty)
      2'b01:   lane_be = 4'b1111;
      2'b10:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      2'b11:   lane_be = 4'b0001 << a;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] ty, input logic [31:0] d);
    case (ty)
      2'b10:   lane_data = {2{d[15:0]}};
      2'b11:   lane_data = {4{d[7:0]}};
      default: lane_data = d;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [29:0]        addr_q [DEPTH];
  logic [29:0]        addr_d [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [31:0]        data_d [DEPTH];
  logic [3:0]         be_q [DEPTH];
  logic [3:0]         be_d [DEPTH];

  logic        st_req, full, push, pop;
  logic [3:0]  new_be;
  logic [31:0] new_data;
  logic [PTR_W-1:0] off;
  logic        unused_ld_lsb;

  assign st_req   = st_valid && (st_type != 2'b00);
  assign full     = (count_q == FULL_CNT);
  assign pop      = (state_q == WAIT_ACK) && mem_ack;
  assign new_be   = lane_be(st_type, st_addr[1:0]);
  assign new_data = lane_data(st_type, st_data);
  assign unused_ld_lsb = ^ld_addr[1:0];

`ifdef STORE_BUF_MERGE_EN
  logic [PTR_W-1:0] tail_m1;
  logic             merge_hit;

  // The entry being offered to memory must not change, so the in-flight head is never a target.
  assign tail_m1   = tail_q - PTR_W'(1);
  assign merge_hit = st_req && (count_q != '0) && (addr_q[tail_m1] == st_addr[31:2]) &&
                     !((state_q == WAIT_ACK) && (tail_m1 == head_q));
  assign st_stall  = full && !merge_hit;
  assign push      = st_req && !full && !merge_hit;
`else
  assign st_stall  = full;
  assign push      = st_req && !full;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;

    if (push) begin
      addr_d[tail_q] = st_addr[31:2];
      data_d[tail_q] = new_data;
      be_d[tail_q]   = new_be;
      tail_d         = tail_q + PTR_W'(1);
    end
`ifdef STORE_BUF_MERGE_EN
    if (merge_hit) begin
      be_d[tail_m1] = be_q[tail_m1] | new_be;
      for (int i = 0; i < 4; i++)
        if (new_be[i]) data_d[tail_m1][8*i +: 8] = new_data[8*i +: 8];
    end
`endif
    if (pop) head_d = head_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Leaving WAIT_ACK always passes through IDLE, giving one idle cycle between requests.
    case (state_q)
      IDLE:     if (count_d != '0) state_d = WAIT_ACK;
      WAIT_ACK: if (mem_ack) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign mem_req   = (state_q == WAIT_ACK);
  assign mem_addr  = mem_req ? {addr_q[head_q], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? data_q[head_q] : 32'h0;
  assign mem_be    = mem_req ? be_q[head_q] : 4'b0000;
  assign buf_empty = (count_q == '0) && (state_q == IDLE);

  always_comb begin
    ld_stall = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if (({1'b0, off} < count_q) && (addr_q[i] == ld_addr[31:2])) ld_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [1:0]  st_type = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_stall, mem_req, ld_stall, buf_empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] ld_addr = 32'h0;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr),
    .st_data(st_data), .st_stall(st_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .ld_addr(ld_addr),
    .ld_stall(ld_stall), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores in arrival order, plus whether the oldest is on the bus.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];
  bit   infl = 0;

  function automatic logic [3:0] m_be(input logic [1:0] ty, input logic [1:0] a);
    if (ty == 2'b01) return 4'b1111;
    if (ty == 2'b10) return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
    case (a)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] m_data(input logic [1:0] ty, input logic [31:0] d);
    if (ty == 2'b01) return d;
    if (ty == 2'b10) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  function automatic bit m_merge_ok();
`ifdef STORE_BUF_MERGE_EN
    if (!(st_valid && st_type != 2'b00) || q.size() == 0) return 0;
    if (q[q.size()-1].a != st_addr[31:2]) return 0;
    if (infl && q.size() == 1) return 0;
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic bit m_stall();
    return (q.size() == DEPTH) && !m_merge_ok();
  endfunction

  function automatic bit m_ld();
    foreach (q[i]) if (q[i].a == ld_addr[31:2]) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      infl = 0;
    end else begin
      bit acc, mrg;
      ent_t e;
      acc = st_valid && (st_type != 2'b00) && !m_stall();
      mrg = acc && m_merge_ok();
      if (infl && mem_ack) void'(q.pop_front());
      e.a  = st_addr[31:2];
      e.be = m_be(st_type, st_addr[1:0]);
      e.d  = m_data(st_type, st_data);
      if (mrg) begin
        for (int l = 0; l < 4; l++)
          if (e.be[l]) q[q.size()-1].d[8*l +: 8] = e.d[8*l +: 8];
        q[q.size()-1].be = q[q.size()-1].be | e.be;
      end else if (acc) begin
        q.push_back(e);
      end
      if (infl) infl = !mem_ack;
      else      infl = (q.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("st_stall", st_stall, m_stall());
      chk("mem_req", mem_req, infl);
      chk("ld_stall", ld_stall, m_ld());
      chk("buf_empty", buf_empty, (q.size() == 0) && !infl);
      if (infl && q.size() > 0) begin
        chk("mem_addr", mem_addr, {q[0].a, 2'b00});
        chk("mem_wdata", mem_wdata, q[0].d);
        chk("mem_be", mem_be, q[0].be);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_type = ty; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0; st_type = 2'b00;
  endtask

  task automatic drain_one(output logic [31:0] a, output logic [3:0] be, output logic [31:0] d);
    int k = 0;
    while (mem_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_chk++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL drain_timeout: actual mem_req %b required 1", mem_req);
    end
    a = mem_addr; be = mem_be; d = mem_wdata;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;

    // Reset state
    @(posedge clk); #1; chk_en = 1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_st_stall", st_stall, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_buf_empty", buf_empty, 1);

    // Byte store issued the next cycle, lane 3, replicated data
    step();
    store(2'b11, 32'h103, 32'h0000_00AB);
    @(negedge clk);
    chk("sb_mem_req", mem_req, 1);
    chk("sb_mem_addr", mem_addr, 32'h100);
    chk("sb_mem_be", mem_be, 4'b1000);
    chk("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    step();
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    @(negedge clk);
    chk("sb_empty_after_ack", buf_empty, 1);

    // Halfword held for five cycles without ack
    step();
    store(2'b10, 32'h202, 32'h0000_1234);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("sh_hold_req", mem_req, 1);
      chk("sh_hold_addr", mem_addr, 32'h200);
      chk("sh_hold_be", mem_be, 4'b1100);
      chk("sh_hold_wdata", mem_wdata, 32'h1234_1234);
      step();
    end
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    @(negedge clk);
    chk("sh_empty_after_ack", buf_empty, 1);

    // Fill to DEPTH, fifth store waits for a pop
    step();
    for (int k = 0; k < 4; k++) store(2'b01, 32'h1000 + 32'(4*k), 32'(k + 1));
    @(negedge clk);
    chk("full_stall", st_stall, 1);
    step();
    st_valid = 1'b1; st_type = 2'b01; st_addr = 32'h1010; st_data = 32'h55;
    @(negedge clk);
    chk("fifth_stalled", st_stall, 1);
    step();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("stall_during_pop", st_stall, 1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stall_released", st_stall, 0);
    step();
    st_valid = 1'b0; st_type = 2'b00;
    for (int k = 1; k < 5; k++) begin
      drain_one(a, be, d);
      chk("fifo_order_addr", a, 32'h1000 + 32'(4*k));
    end
    chk("fifo_last_data", d, 32'h55);

    // Load hazard against a pending word
    step();
    store(2'b01, 32'h300, 32'hDEAD_BEEF);
    ld_addr = 32'h302;
    @(negedge clk);
    chk("ld_hit", ld_stall, 1);
    step();
    ld_addr = 32'h304;
    @(negedge clk);
    chk("ld_miss", ld_stall, 0);
    step();
    ld_addr = 32'h0;
    drain_one(a, be, d);
    chk("ld_drain_addr", a, 32'h300);

    // Two bytes of one word behind a busy head
    step();
    store(2'b01, 32'h500, 32'h0);
    store(2'b11, 32'h400, 32'h11);
    store(2'b11, 32'h401, 32'h22);
    drain_one(a, be, d);
    chk("merge_head_addr", a, 32'h500);
    drain_one(a, be, d);
    chk("merge_addr", a, 32'h400);
`ifdef STORE_BUF_MERGE_EN
    chk("merge_be", be, 4'b0011);
    chk("merge_data", d[15:0], 32'h2211);
`else
    chk("nomerge_be0", be, 4'b0001);
    chk("nomerge_data0", d[7:0], 32'h11);
    drain_one(a, be, d);
    chk("nomerge_addr1", a, 32'h400);
    chk("nomerge_be1", be, 4'b0010);
    chk("nomerge_data1", d[15:8], 32'h22);
`endif

    // Reset while a request is outstanding; the late ack is ignored
    step();
    store(2'b01, 32'h600, 32'h1);
    store(2'b01, 32'h604, 32'h2);
    store(2'b01, 32'h608, 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_req", mem_req, 0);
    chk("rst_wait_empty", buf_empty, 1);
    step();
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_empty", buf_empty, 1);
    chk("late_ack_stall", st_stall, 0);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
